mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 64 KiB memory port between two requesters: the CPU (port C) and a DMA/program-loader engine (port D).
- Sits between cpu_top's memory interface and the ROM/RAM array.
- Uses fixed CPU priority with a starvation guard for DMA.
- Enforces ROM write protection: addresses below ROM_LIMIT are read-only.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
ROM_LIMIT, 16'h0100, first writable address; writes below it are blocked
MAX_WAIT, 4, consecutive lost arbitrations after which DMA is forced to win (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
cpu_req  in  1  CPU transfer request; payload held valid while high
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  one-cycle pulse: sampled CPU payload accepted
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same as CPU port
dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  same as CPU port
mem_addr  out  ADDR_W  memory address
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd
rom_wr_err  out  1  one-cycle pulse on a blocked ROM write
err_cnt  out  8  saturating count of blocked writes
owner  out  2  01 = CPU, 10 = DMA, 00 = idle; owner of the current cycle's memory access

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, starvation counter is 0, pending read tags are cleared.
  - A read in flight when reset asserts never produces rvalid.
  - Reset release is synchronous to clk.
- Arbitration happens at each rising edge. At most one transfer is accepted per edge.
  - Winner when only one req is high: that port.
  - Winner when both are high: CPU, unless wait_cnt == MAX_WAIT, in which case DMA wins.
- wait_cnt (4-bit):
  - increments on each edge where dma_req=1 and DMA loses;
  - clears when DMA wins or when dma_req=0;
  - never exceeds MAX_WAIT.
- All outputs are registered. For a payload accepted at edge E:
  - cycle E+1: winner's gnt=1, owner set, mem_addr/mem_wdata/mem_rd or mem_wr driven.
  - cycle E+2, reads only: winner's rvalid=1 and its rdata = mem_rdata (combinational mux by registered tag). The other port's rdata is 0.
- Requester rule:
  - During a gnt cycle, the requester presents its next payload or drops req.
  - A req still high at the next edge is a new transfer, giving back-to-back throughput of 1 transfer per cycle.
  - Payload changes while req=1 and gnt not yet received are illegal (assertion in bench).
- ROM protect: for an accepted write with addr < ROM_LIMIT:
  - gnt pulses normally;
  - mem_wr=0 and mem_rd=0;
  - rom_wr_err=1 in the same cycle;
  - err_cnt increments, saturating at 255.
- Reads of any address are always permitted.
- No request: mem_rd=mem_wr=0, owner=00. mem_addr/mem_wdata hold their last values.
- Back-to-back reads from alternating owners are permitted. Read tags form a 1-deep pipeline per cycle, so there is no conflict.

Decomposition:
- Shared package mem_map_pkg (header alongside instructions.vh):
  - ROM_LIMIT, ADDR_W, DATA_W;
  - owner encodings OWN_IDLE=2'b00, OWN_CPU=2'b01, OWN_DMA=2'b10.
- One natural sub-module: arb_starve_ctr (wait counter plus forced-grant decision). Everything else stays in the top.

Test Plan:
- Reset: hold reset=0 with requests active → all outputs 0, err_cnt=0. Release → first gnt one cycle after the first sampling edge.
- CPU read 0x0005, memory returns 0x55 → cpu_gnt, mem_rd=1, mem_addr=0x0005 in E+1; cpu_rvalid=1, cpu_rdata=0x55 in E+2; no DMA activity.
- cpu_req and dma_req held high continuously, MAX_WAIT=4 → grant sequence C,C,C,C,D repeating; wait_cnt peaks at 4.
- DMA write 0x0100←0xAA → mem_wr=1, mem_addr=0x0100, mem_wdata=0xAA. DMA write 0x00FF←0x11 → dma_gnt=1, mem_wr=0, rom_wr_err=1, err_cnt=1.
- CPU back-to-back reads 0x0000/0x0001/0x0002 (ROM 0x55,0x02,0xAA) → gnt on 3 consecutive cycles; rvalid on 3 consecutive cycles returning 0x55,0x02,0xAA.
- CPU read accepted, then reset pulsed low in the mem_rd cycle → no cpu_rvalid afterwards; outputs 0 immediately; normal grants resume after release.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the memory bus arbiter slice.
// Holds the bus widths, the ROM write-protect boundary, the default
// starvation limit and the owner encodings reported on the owner port.
package mem_map_pkg;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 8;
  localparam logic [15:0] ROM_LIMIT = 16'h0100;
  localparam int          MAX_WAIT  = 4;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// arb_starve_ctr: DMA starvation guard.
// Counts consecutive edges on which DMA requested but lost to the CPU.
// Once the count reaches MAX_WAIT, dma_force is raised so that DMA
// wins the next contested arbitration.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low
//   cpu_req   CPU request
//   dma_req   DMA request
//   dma_force DMA must win a contested arbitration this cycle
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_req,
  output logic dma_force
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       dma_loses;

  // DMA only loses when both request and the guard is not yet active,
  // so the counter can never step past WAIT_LIMIT.
  always_comb begin
    dma_force = (wait_cnt == WAIT_LIMIT);
    dma_loses = dma_req && cpu_req && !dma_force;
  end

  // Any edge where DMA wins or stops requesting restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (dma_loses) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the CPU (port C)
// and the DMA/program-loader engine (port D).
// Fixed CPU priority with a DMA starvation guard; writes below ROM_LIMIT
// are blocked, flagged on rom_wr_err and counted in err_cnt.
// Ports:
//   clk, reset                           clock, async active-low reset
//   cpu_req/we/addr/wdata                CPU request payload
//   cpu_gnt, cpu_rvalid, cpu_rdata       CPU grant pulse and read return
//   dma_req/we/addr/wdata                DMA request payload
//   dma_gnt, dma_rvalid, dma_rdata       DMA grant pulse and read return
//   mem_addr, mem_rd, mem_wr, mem_wdata  memory command (registered)
//   mem_rdata                            memory data, valid after mem_rd
//   rom_wr_err, err_cnt                  blocked-write pulse and count
//   owner                                owner of this cycle's access
module mem_bus_arbiter #(
  parameter int                      ADDR_W    = mem_map_pkg::ADDR_W,
  parameter int                      DATA_W    = mem_map_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]       ROM_LIMIT = mem_map_pkg::ROM_LIMIT,
  parameter int                      MAX_WAIT  = mem_map_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rom_wr_err,
  output logic [7:0]        err_cnt,
  output logic [1:0]        owner
);

  import mem_map_pkg::*;

  logic              dma_force;
  logic              cpu_win;
  logic              dma_win;
  logic              any_win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rom_block;
  owner_e            owner_q;

  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .dma_force (dma_force)
  );

  // Pick the winner of this edge and steer its payload onto the bus.
  always_comb begin
    cpu_win   = cpu_req && !(dma_req && dma_force);
    dma_win   = dma_req && !cpu_win;
    any_win   = cpu_win || dma_win;
    sel_we    = dma_win ? dma_we    : cpu_we;
    sel_addr  = dma_win ? dma_addr  : cpu_addr;
    sel_wdata = dma_win ? dma_wdata : cpu_wdata;
    rom_block = any_win && sel_we && (sel_addr < ROM_LIMIT);
  end

  // Register the accepted command. The read-return valids are derived
  // from the previous cycle's mem_rd and owner, which act as the read tag;
  // clearing them on reset drops any read that was in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      owner_q    <= OWN_IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      rom_wr_err <= 1'b0;
      err_cnt    <= '0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_gnt    <= cpu_win;
      dma_gnt    <= dma_win;
      owner_q    <= cpu_win ? OWN_CPU : (dma_win ? OWN_DMA : OWN_IDLE);
      if (any_win) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      mem_rd     <= any_win && !sel_we;
      mem_wr     <= any_win && sel_we && !rom_block;
      rom_wr_err <= rom_block;
      if (rom_block && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      cpu_rvalid <= mem_rd && (owner_q == OWN_CPU);
      dma_rvalid <= mem_rd && (owner_q == OWN_DMA);
    end
  end

  // Memory data is routed only to the port whose read is returning.
  always_comb begin
    owner     = owner_q;
    cpu_rdata = cpu_rvalid ? mem_rdata : '0;
    dma_rdata = dma_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam logic [15:0] TB_ROM_LIMIT = 16'h0100;
  localparam int          TB_MAX_WAIT  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic [7:0]  mem_wdata, err_cnt;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic        mem_rd, mem_wr, rom_wr_err;
  logic [1:0]  owner;

  int checks = 0;
  int failures = 0;

  logic [7:0] env_mem [0:65535];
  logic [7:0] exp_mem [0:65535];

  // Expected outputs for the current cycle
  logic        e_cpu_gnt, e_dma_gnt, e_rd, e_wr, e_err;
  logic        e_cpu_rvalid, e_dma_rvalid;
  logic [7:0]  e_cpu_rdata, e_dma_rdata, e_wdata, e_errcnt;
  logic [15:0] e_addr;
  logic [1:0]  e_owner;
  int          losses;

  mem_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rom_wr_err (rom_wr_err),
    .err_cnt    (err_cnt),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  // Memory array behind the arbiter: data returns the cycle after mem_rd
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= env_mem[mem_addr];
  end

  function automatic logic [7:0] initVal(input int a);
    case (a)
      0: return 8'h55;
      1: return 8'h02;
      2: return 8'hAA;
      5: return 8'h55;
      default: return 8'((a * 7) ^ (a >> 8) ^ 8'h3C);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    e_cpu_gnt = 0; e_dma_gnt = 0; e_rd = 0; e_wr = 0; e_err = 0;
    e_cpu_rvalid = 0; e_dma_rvalid = 0; e_cpu_rdata = 0; e_dma_rdata = 0;
    e_wdata = 0; e_errcnt = 0; e_addr = 0; e_owner = 0; losses = 0;
  endtask

  // One arbitration edge of the reference model
  task automatic modelEdge();
    logic       ret_cpu, ret_dma, dma_turn, we, blocked;
    logic [7:0] ret_val;
    int         winner;
    ret_cpu = e_rd && (e_owner == 2'b01);
    ret_dma = e_rd && (e_owner == 2'b10);
    ret_val = exp_mem[e_addr];
    if (e_wr) exp_mem[e_addr] = e_wdata;

    dma_turn = dma_req && cpu_req && (losses >= TB_MAX_WAIT);
    if (cpu_req && !dma_turn) winner = 1;
    else if (dma_req) winner = 2;
    else winner = 0;
    if (dma_req && winner == 1) losses++;
    else losses = 0;

    e_cpu_gnt = (winner == 1);
    e_dma_gnt = (winner == 2);
    e_owner = 2'(winner);
    e_rd = 0; e_wr = 0; e_err = 0;
    if (winner != 0) begin
      we      = (winner == 1) ? cpu_we : dma_we;
      e_addr  = (winner == 1) ? cpu_addr : dma_addr;
      e_wdata = (winner == 1) ? cpu_wdata : dma_wdata;
      blocked = we && (e_addr < TB_ROM_LIMIT);
      e_rd  = !we;
      e_wr  = we && !blocked;
      e_err = blocked;
      if (blocked && e_errcnt < 8'd255) e_errcnt++;
    end
    e_cpu_rvalid = ret_cpu;
    e_dma_rvalid = ret_dma;
    e_cpu_rdata  = ret_cpu ? ret_val : 8'h00;
    e_dma_rdata  = ret_dma ? ret_val : 8'h00;
  endtask

  task automatic checkAll();
    checkOutput("cpu_gnt",    32'(cpu_gnt),    32'(e_cpu_gnt));
    checkOutput("dma_gnt",    32'(dma_gnt),    32'(e_dma_gnt));
    checkOutput("owner",      32'(owner),      32'(e_owner));
    checkOutput("mem_rd",     32'(mem_rd),     32'(e_rd));
    checkOutput("mem_wr",     32'(mem_wr),     32'(e_wr));
    checkOutput("mem_addr",   32'(mem_addr),   32'(e_addr));
    checkOutput("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
    checkOutput("rom_wr_err", 32'(rom_wr_err), 32'(e_err));
    checkOutput("err_cnt",    32'(err_cnt),    32'(e_errcnt));
    checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cpu_rvalid));
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(e_dma_rvalid));
    checkOutput("cpu_rdata",  32'(cpu_rdata),  32'(e_cpu_rdata));
    checkOutput("dma_rdata",  32'(dma_rdata),  32'(e_dma_rdata));
  endtask

  // Advance one clock; inputs are driven between negedges only
  task automatic stepCycle();
    @(posedge clk);
    if (reset) modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic applyStimulus(input logic cr, input logic cw,
                               input logic [15:0] ca, input logic [7:0] cd,
                               input logic dr, input logic dw,
                               input logic [15:0] da, input logic [7:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 3))
      0: return 16'($urandom_range(16'h00FC, 16'h0103));
      1: return 16'($urandom_range(0, 16'h01FF));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) begin
      env_mem[a] = initVal(a);
      exp_mem[a] = initVal(a);
    end
    modelReset();

    // Reset held with both requests active: everything stays at zero
    reset = 1'b0;
    applyStimulus(1, 0, 16'h0003, 8'h00, 1, 1, 16'h0200, 8'h77);
    #1;
    checkAll();
    for (int i = 0; i < 3; i++) stepCycle();
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();

    // Release, then a single CPU read of 0x0005
    reset = 1'b1;
    applyStimulus(1, 0, 16'h0005, 8'h00, 0, 0, 16'h0, 8'h0);
    stepCycle();
    checkOutput("rd5_gnt", 32'(cpu_gnt), 32'd1);
    checkOutput("rd5_addr", 32'(mem_addr), 32'h0005);
    applyStimulus(0, 0, 16'h0005, 8'h00, 0, 0, 16'h0, 8'h0);
    stepCycle();
    checkOutput("rd5_rdata", 32'(cpu_rdata), 32'h55);
    stepCycle();

    // Both requesting continuously: C,C,C,C,D repeating
    applyStimulus(1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("fair_dma_gnt", 32'(dma_gnt), 32'((i % 5) == 4));
    end
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();
    stepCycle();

    // DMA write just above and just below the ROM boundary
    applyStimulus(0, 0, 16'h0, 8'h0, 1, 1, 16'h0100, 8'hAA);
    stepCycle();
    checkOutput("wr100_mem_wr", 32'(mem_wr), 32'd1);
    applyStimulus(0, 0, 16'h0, 8'h0, 1, 1, 16'h00FF, 8'h11);
    stepCycle();
    checkOutput("wrFF_err", 32'(rom_wr_err), 32'd1);
    checkOutput("wrFF_cnt", 32'(err_cnt), 32'd1);
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();

    // CPU back-to-back reads of 0x0000..0x0002
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 16'(i), 8'h00, 0, 0, 16'h0, 8'h0);
      stepCycle();
      checkOutput("b2b_gnt", 32'(cpu_gnt), 32'd1);
    end
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();
    checkOutput("b2b_last_rdata", 32'(cpu_rdata), 32'hAA);
    stepCycle();

    // Randomized traffic respecting the hold-until-grant rule
    for (int i = 0; i < 400; i++) begin
      if (!cpu_req || e_cpu_gnt) begin
        cpu_req = ($urandom_range(0, 99) < 60); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = randAddr(); cpu_wdata = 8'($urandom);
      end
      if (!dma_req || e_dma_gnt) begin
        dma_req = ($urandom_range(0, 99) < 60); dma_we = 1'($urandom_range(0, 1));
        dma_addr = randAddr(); dma_wdata = 8'($urandom);
      end
      stepCycle();
    end

    // Enough blocked writes to saturate the error counter
    applyStimulus(0, 0, 16'h0, 8'h0, 1, 1, 16'h0010, 8'h5A);
    for (int i = 0; i < 260; i++) stepCycle();
    checkOutput("err_cnt_sat", 32'(err_cnt), 32'd255);
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();
    stepCycle();

    // Reset during the mem_rd cycle of a CPU read kills the return
    applyStimulus(1, 0, 16'h0005, 8'h00, 0, 0, 16'h0, 8'h0);
    stepCycle();
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_mid_gnt", 32'(cpu_gnt), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checkOutput("rst_mid_rvalid", 32'(cpu_rvalid), 32'd0);
    end
    reset = 1'b1;
    applyStimulus(1, 0, 16'h0001, 8'h00, 0, 0, 16'h0, 8'h0);
    stepCycle();
    checkOutput("post_rst_gnt", 32'(cpu_gnt), 32'd1);
    applyStimulus(0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0);
    stepCycle();
    checkOutput("post_rst_rdata", 32'(cpu_rdata), 32'h02);
    stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
